moore_seq_tx: RTL and testbench



---
 rtl/moore_seq_tx.sv | 125 ++++++++++++
 tb/tb_moore_seq_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/moore_seq_tx.sv
// rtl/moore_seq_tx.sv - Moore serial pattern transmitter, MSB-first, repeats with idle gaps.
// Optional even-parity bit per frame when MOORE_SEQ_TX_PARITY_EN is defined.
module moore_seq_tx #(
   parameter int W          = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         LOAD_VALID,
   output logic         LOAD_READY,
   input  logic [W-1:0] PATTERN,
   input  logic [7:0]   REPEAT,
   output logic         I,
   output logic         FRAME,
   output logic         DONE,
   output logic         Qa,
   output logic         Qb
);

   localparam int BW = $clog2(W + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_GAP   = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t          state;
   logic [W-1:0]    sreg;
   logic [W-1:0]    hold;
   logic [7:0]      rep_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [GW-1:0]   gap_cnt;
   logic            frame_end;

`ifdef MOORE_SEQ_TX_PARITY_EN
   logic            par_phase;

   // Frame ends on the parity cycle that follows the last pattern bit.
   assign frame_end = par_phase;
`else
   assign frame_end = (bit_cnt == '0);
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         sreg    <= '0;
         hold    <= '0;
         rep_cnt <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
`ifdef MOORE_SEQ_TX_PARITY_EN
         par_phase <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (LOAD_VALID) begin
                  sreg    <= PATTERN;
                  hold    <= PATTERN;
                  rep_cnt <= REPEAT;
                  bit_cnt <= BIT_LAST;
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (!frame_end) begin
`ifdef MOORE_SEQ_TX_PARITY_EN
                  if (bit_cnt == '0) begin
                     par_phase <= 1'b1;
                     sreg      <= {^hold, {(W-1){1'b0}}};
                  end else begin
                     sreg    <= sreg << 1;
                     bit_cnt <= bit_cnt - 1'b1;
                  end
`else
                  sreg    <= sreg << 1;
                  bit_cnt <= bit_cnt - 1'b1;
`endif
               end else begin
`ifdef MOORE_SEQ_TX_PARITY_EN
                  par_phase <= 1'b0;
`endif
                  if (rep_cnt == '0) begin
                     state <= S_DONE;
                  end else begin
                     rep_cnt <= rep_cnt - 1'b1;
                     sreg    <= hold;
                     bit_cnt <= BIT_LAST;
                     if (GAP_CYCLES == 0) begin
                        state <= S_SHIFT;
                     end else begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LAST;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_SHIFT;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign LOAD_READY = (state == S_IDLE);
   assign FRAME      = (state == S_SHIFT);
   assign I          = FRAME & sreg[W-1];
   assign DONE       = (state == S_DONE);
   assign Qa         = state[1];
   assign Qb         = state[0];

endmodule

// File: tb/tb_moore_seq_tx.sv
// tb/tb_moore_seq_tx.sv - directed bench for moore_seq_tx (GAP=2 and GAP=0 instances).
// Expectations follow MOORE_SEQ_TX_PARITY_EN when defined.
module tb_moore_seq_tx;

   localparam int W = 8;
`ifdef MOORE_SEQ_TX_PARITY_EN
   localparam int PAR = 1;
   localparam logic [63:0] EXP_A5   = 64'h14A;
   localparam logic [63:0] EXP_F0_I = 64'h1E03C0;
   localparam logic [63:0] EXP_F0_F = 64'h1FF3FE;
   localparam logic [63:0] EXP_81   = 64'h102;
   localparam logic [63:0] EXP_Z_I  = 64'hC0603;
`else
   localparam int PAR = 0;
   localparam logic [63:0] EXP_A5   = 64'hA5;
   localparam logic [63:0] EXP_F0_I = 64'h781E0;
   localparam logic [63:0] EXP_F0_F = 64'h7F9FE;
   localparam logic [63:0] EXP_81   = 64'h81;
   localparam logic [63:0] EXP_Z_I  = 64'h010101;
`endif
   localparam int FL = W + PAR;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lv, lr, i_s, frame, done, qa, qb;
   logic [7:0] pat, rep;
   logic       lv0, lr0, i0, frame0, done0, qa0, qb0;
   logic [7:0] pat0, rep0;

   int errors = 0;
   int checks = 0;
   logic [63:0] iv, fv;
   int ndone, busy;

   always #5 clk = ~clk;

   moore_seq_tx #(.W(W), .GAP_CYCLES(2)) u_dut (
      .CLK(clk), .RST_N(rst_n), .LOAD_VALID(lv), .LOAD_READY(lr),
      .PATTERN(pat), .REPEAT(rep), .I(i_s), .FRAME(frame),
      .DONE(done), .Qa(qa), .Qb(qb)
   );

   moore_seq_tx #(.W(W), .GAP_CYCLES(0)) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .LOAD_VALID(lv0), .LOAD_READY(lr0),
      .PATTERN(pat0), .REPEAT(rep0), .I(i0), .FRAME(frame0),
      .DONE(done0), .Qa(qa0), .Qb(qb0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] p, input logic [7:0] r);
      @(negedge clk);
      pat = p;
      rep = r;
      lv  = 1'b1;
      @(posedge clk);
      #1 lv = 1'b0;
   endtask

   task automatic load0(input logic [7:0] p, input logic [7:0] r);
      @(negedge clk);
      pat0 = p;
      rep0 = r;
      lv0  = 1'b1;
      @(posedge clk);
      #1 lv0 = 1'b0;
   endtask

   initial begin
      lv = 1'b0; pat = '0; rep = '0;
      lv0 = 1'b0; pat0 = '0; rep0 = '0;

      #12;
      check("rst_i", i_s, 1'b0);
      check("rst_frame", frame, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_q", {qa, qb}, 2'b00);
      check("rst_ready", lr, 1'b1);
      check("rst_ready0", lr0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // 8'hA5 single frame, with a load attempt while busy
      load(8'hA5, 8'd0);
      iv = '0; fv = '0; ndone = 0;
      for (int k = 1; k <= FL + 2; k++) begin
         @(negedge clk);
         if (k <= FL) begin
            iv = {iv[62:0], i_s};
            fv = {fv[62:0], frame};
         end
         if (k == 1) check("a5_q_shift", {qa, qb}, 2'b01);
         if (k == 3) begin
            pat = 8'hFF;
            lv  = 1'b1;
         end
         if (k == FL) lv = 1'b0;
         if (k == FL + 1) begin
            check("a5_done", done, 1'b1);
            check("a5_q_done", {qa, qb}, 2'b11);
         end
         if (k == FL + 2) begin
            check("a5_ready", lr, 1'b1);
            check("a5_q_idle", {qa, qb}, 2'b00);
         end
         ndone += int'(done);
      end
      check("a5_bits", iv, EXP_A5);
      check("a5_frame", fv, (64'd1 << FL) - 1);
      check("a5_done_pulses", ndone, 1);

      // 8'hF0 with one repeat and a two-cycle gap
      load(8'hF0, 8'd1);
      iv = '0; fv = '0; busy = 0;
      for (int k = 1; k <= 2 * FL + 4; k++) begin
         @(negedge clk);
         if (k <= 2 * FL + 3) begin
            iv = {iv[62:0], i_s};
            fv = {fv[62:0], frame};
            busy += int'(!lr);
         end
         if (k == FL + 1) check("f0_q_gap", {qa, qb}, 2'b10);
         if (k == 2 * FL + 3) check("f0_done", done, 1'b1);
         if (k == 2 * FL + 4) check("f0_ready", lr, 1'b1);
      end
      check("f0_bits", iv, EXP_F0_I);
      check("f0_frame", fv, EXP_F0_F);
      check("f0_busy", busy, 2 * FL + 3);

      // asynchronous reset in the middle of 8'h3C
      load(8'h3C, 8'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 3) check("3c_bit3", i_s, 1'b1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_i", i_s, 1'b0);
      check("mid_rst_frame", frame, 1'b0);
      check("mid_rst_q", {qa, qb}, 2'b00);
      check("mid_rst_ready", lr, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      load(8'h81, 8'd0);
      iv = '0;
      for (int k = 1; k <= FL + 2; k++) begin
         @(negedge clk);
         if (k <= FL) iv = {iv[62:0], i_s};
         if (k == FL + 1) check("81_done", done, 1'b1);
      end
      check("81_bits", iv, EXP_81);

      // zero-gap instance: three back-to-back frames of 8'h01
      load0(8'h01, 8'd2);
      iv = '0; fv = '0;
      for (int k = 1; k <= 3 * FL + 2; k++) begin
         @(negedge clk);
         if (k <= 3 * FL) begin
            iv = {iv[62:0], i0};
            fv = {fv[62:0], frame0};
         end
         if (k == 3 * FL + 1) check("zg_done", done0, 1'b1);
         if (k == 3 * FL + 2) check("zg_ready", lr0, 1'b1);
      end
      check("zg_bits", iv, EXP_Z_I);
      check("zg_frame", fv, (64'd1 << (3 * FL)) - 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
